// File: rtl/disp_pixbuf.sv
// disp_pixbuf: pixel FIFO between the VRAM AXI read port and the display
// pipeline. Stores 64-bit words ({P1,P0}, RGB in the low 24 bits of each
// 32-bit half) and unpacks them into one 24-bit pixel per handshake.
// Optional macro DISP_PIXBUF_ERR_EN enables the sticky ERR_OVF/ERR_UDF flags;
// when undefined both outputs are tied low and no flag registers exist.
module disp_pixbuf #(
    parameter int DEPTH     = 64,
    parameter int BURST_LEN = 16
) (
    input  logic                    ACLK,
    input  logic                    ARST,
    input  logic [63:0]             RDATA,
    input  logic                    RVALID,
    input  logic                    RREADY,
    input  logic                    FLUSH,
    output logic                    BUF_WREADY,
    output logic [23:0]             PIX_DATA,
    output logic                    PIX_VALID,
    input  logic                    PIX_READY,
    output logic [$clog2(DEPTH):0]  LEVEL,
    output logic                    ERR_OVF,
    output logic                    ERR_UDF
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW:0]   BURST_W  = (LW + 1)'(BURST_LEN);

    // Only the two RGB fields of each word are kept.
    logic [47:0]    mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           half_q, half_d;
    logic           pix_valid_q, pix_valid_d;
    logic [23:0]    pix_data_q, pix_data_d;

    logic           push_req_s;
    logic           full_s;
    logic           avail_s;
    logic           load_s;
    logic           pop_s;
    logic           push_ok_s;
    logic [47:0]    head_s;
    logic [LW:0]    space_s;
    logic           unused_s;

    assign unused_s = ^{RDATA[63:56], RDATA[31:24]};

    // Handshake decode: a pop happens only when P1 of the head word is loaded,
    // which frees a slot so a push into a full FIFO can be accepted alongside.
    always_comb begin
        push_req_s = RVALID & RREADY & ~FLUSH;
        full_s     = (level_q == FULL_LVL);
        avail_s    = (level_q != {LW{1'b0}});
        load_s     = (~pix_valid_q | PIX_READY) & avail_s & ~FLUSH;
        pop_s      = load_s & half_q;
        push_ok_s  = push_req_s & (~full_s | pop_s);
        head_s     = mem_q[rptr_q];
        space_s    = {1'b0, FULL_LVL} - {1'b0, level_q};
    end

    // Storage write; contents need no reset because LEVEL gates every read.
    always_ff @(posedge ACLK) begin
        if (push_ok_s) begin
            mem_q[wptr_q] <= {RDATA[55:32], RDATA[23:0]};
        end
    end

    // Next-state for pointers, fill level and the output pixel register.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        half_d      = half_q;
        pix_valid_d = pix_valid_q;
        pix_data_d  = pix_data_q;
        if (FLUSH) begin
            wptr_d      = {AW{1'b0}};
            rptr_d      = {AW{1'b0}};
            level_d     = {LW{1'b0}};
            half_d      = 1'b0;
            pix_valid_d = 1'b0;
        end else begin
            if (push_ok_s) begin
                wptr_d = wptr_q + 1'b1;
            end else begin
                wptr_d = wptr_q;
            end
            case ({push_ok_s, pop_s})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (load_s) begin
                pix_valid_d = 1'b1;
                pix_data_d  = half_q ? head_s[47:24] : head_s[23:0];
                half_d      = ~half_q;
                rptr_d      = half_q ? (rptr_q + 1'b1) : rptr_q;
            end else if (PIX_READY) begin
                // Current pixel consumed (or none held) and nothing to refill.
                pix_valid_d = 1'b0;
            end else begin
                pix_valid_d = pix_valid_q;
            end
        end
    end

    // State register; ARST overrides FLUSH and all traffic.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            wptr_q      <= {AW{1'b0}};
            rptr_q      <= {AW{1'b0}};
            level_q     <= {LW{1'b0}};
            half_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= 24'h000000;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            half_q      <= half_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
        end
    end

    assign BUF_WREADY = (space_s >= BURST_W);
    assign PIX_DATA   = pix_data_q;
    assign PIX_VALID  = pix_valid_q;
    assign LEVEL      = level_q;

`ifdef DISP_PIXBUF_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;
    logic armed_q, armed_d;

    // Sticky error flags; underflow is only meaningful once a frame has started.
    always_comb begin
        if (FLUSH) begin
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
            armed_d = 1'b0;
        end else begin
            ovf_d   = ovf_q | (push_req_s & full_s & ~pop_s);
            udf_d   = udf_q | (armed_q & PIX_READY & ~pix_valid_q);
            armed_d = armed_q | (pix_valid_q & PIX_READY);
        end
    end

    // Error flag registers.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            armed_q <= armed_d;
        end
    end

    assign ERR_OVF = ovf_q;
    assign ERR_UDF = udf_q;
`else
    assign ERR_OVF = 1'b0;
    assign ERR_UDF = 1'b0;
`endif

endmodule

// File: tb/tb_disp_pixbuf.sv
// Self-checking bench for disp_pixbuf (DEPTH=64, BURST_LEN=16). Expected
// pixels come from a queue fed with the unpacked pixels of every word the
// bench knows to be accepted; directed cases cover reset, latency, space
// threshold, overflow, full push+pop, flush and underflow, followed by a
// randomized burst stream.
module tb_disp_pixbuf;

`ifdef DISP_PIXBUF_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic        ACLK;
    logic        ARST;
    logic [63:0] RDATA;
    logic        RVALID;
    logic        RREADY;
    logic        FLUSH;
    logic        BUF_WREADY;
    logic [23:0] PIX_DATA;
    logic        PIX_VALID;
    logic        PIX_READY;
    logic [6:0]  LEVEL;
    logic        ERR_OVF;
    logic        ERR_UDF;

    int total = 0;
    int bad   = 0;
    int npix  = 0;
    logic [23:0] exp_q[$];

    disp_pixbuf #(.DEPTH(64), .BURST_LEN(16)) dut (
        .ACLK(ACLK), .ARST(ARST), .RDATA(RDATA), .RVALID(RVALID),
        .RREADY(RREADY), .FLUSH(FLUSH), .BUF_WREADY(BUF_WREADY),
        .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
        .LEVEL(LEVEL), .ERR_OVF(ERR_OVF), .ERR_UDF(ERR_UDF)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a word yields P0 = bits[23:0] then P1 = bits[55:32].
    task automatic push_model(input logic [63:0] w);
        exp_q.push_back(w[23:0]);
        exp_q.push_back(w[55:32]);
    endtask

    // One clock cycle: drive inputs, score a pixel handshake, advance.
    task automatic cyc(input logic rv, input logic [63:0] rd, input logic pr, input logic fl);
        RVALID = rv; RDATA = rd; PIX_READY = pr; FLUSH = fl;
        if (PIX_VALID && PIX_READY) begin
            npix++;
            if (exp_q.size() == 0) chk_eq("extra_pix", {40'd0, PIX_DATA}, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk_eq("pix", {40'd0, PIX_DATA}, {40'd0, exp_q.pop_front()});
        end
        @(posedge ACLK); #1;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || PIX_VALID) && n < bound) begin
            cyc(1'b0, 64'd0, PIX_VALID, 1'b0);
            n++;
        end
        chk_eq("drain_left", 64'(exp_q.size()), 64'd0);
        chk_eq("drain_level", {57'd0, LEVEL}, 64'd0);
    endtask

    task automatic do_reset();
        ARST = 1'b1; RVALID = 1'b0; RDATA = 64'd0; PIX_READY = 1'b0; FLUSH = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        ARST = 1'b0;
        exp_q.delete();
    endtask

    task automatic fill(input int n);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            push_model(w);
            cyc(1'b1, w, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [63:0] w;
        int n;
        int left;
        int sent;
        int pix0;
        RREADY = 1'b1;
        do_reset();

        // Reset state
        chk_eq("rst_level", {57'd0, LEVEL}, 64'd0);
        chk_eq("rst_valid", {63'd0, PIX_VALID}, 64'd0);
        chk_eq("rst_data", {40'd0, PIX_DATA}, 64'd0);
        chk_eq("rst_wready", {63'd0, BUF_WREADY}, 64'd1);
        chk_eq("rst_ovf", {63'd0, ERR_OVF}, 64'd0);
        chk_eq("rst_udf", {63'd0, ERR_UDF}, 64'd0);

        // Single word: latency and unpack order
        w = 64'h00AABBCC_00112233;
        push_model(w);
        cyc(1'b1, w, 1'b1, 1'b0);
        chk_eq("one_level1", {57'd0, LEVEL}, 64'd1);
        chk_eq("one_notyet", {63'd0, PIX_VALID}, 64'd0);
        cyc(1'b0, 64'd0, 1'b1, 1'b0);
        chk_eq("one_valid", {63'd0, PIX_VALID}, 64'd1);
        chk_eq("one_p0", {40'd0, PIX_DATA}, 64'h112233);
        cyc(1'b0, 64'd0, 1'b1, 1'b0);
        chk_eq("one_p1", {40'd0, PIX_DATA}, 64'hAABBCC);
        chk_eq("one_level0", {57'd0, LEVEL}, 64'd0);
        cyc(1'b0, 64'd0, 1'b1, 1'b0);
        chk_eq("one_empty", {63'd0, PIX_VALID}, 64'd0);
        cyc(1'b0, 64'd0, 1'b0, 1'b0);
        chk_eq("udf_quiet", {63'd0, ERR_UDF}, 64'd0);

        // Underflow after first pixel of frame, cleared by FLUSH
        cyc(1'b0, 64'd0, 1'b1, 1'b0);
        chk_eq("udf_set", {63'd0, ERR_UDF}, {63'd0, ERR_ON});
        cyc(1'b0, 64'd0, 1'b0, 1'b1);
        chk_eq("udf_flush", {63'd0, ERR_UDF}, 64'd0);

        // Space threshold and overflow
        do_reset();
        fill(48);
        chk_eq("lvl48", {57'd0, LEVEL}, 64'd48);
        chk_eq("wready48", {63'd0, BUF_WREADY}, 64'd1);
        fill(1);
        chk_eq("lvl49", {57'd0, LEVEL}, 64'd49);
        chk_eq("wready49", {63'd0, BUF_WREADY}, 64'd0);
        fill(15);
        chk_eq("lvl64", {57'd0, LEVEL}, 64'd64);
        cyc(1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0);
        chk_eq("ovf_level", {57'd0, LEVEL}, 64'd64);
        chk_eq("ovf_flag", {63'd0, ERR_OVF}, {63'd0, ERR_ON});
        drain(300);

        // Full FIFO: push together with P1 load, then full-rate drain
        do_reset();
        fill(64);
        w = {$urandom, $urandom};
        push_model(w);
        cyc(1'b1, w, 1'b1, 1'b0);
        chk_eq("fullpp_level", {57'd0, LEVEL}, 64'd64);
        chk_eq("fullpp_ovf", {63'd0, ERR_OVF}, 64'd0);
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            cyc(1'b0, 64'd0, PIX_VALID, 1'b0);
            n++;
        end
        chk_eq("throughput", 64'(n), 64'd129);
        drain(10);

        // FLUSH with simultaneous push
        do_reset();
        fill(20);
        chk_eq("fl_lvl20", {57'd0, LEVEL}, 64'd20);
        chk_eq("fl_valid", {63'd0, PIX_VALID}, 64'd1);
        exp_q.delete();
        cyc(1'b1, 64'h1111_1111_2222_2222, 1'b0, 1'b1);
        chk_eq("fl_level", {57'd0, LEVEL}, 64'd0);
        chk_eq("fl_nvalid", {63'd0, PIX_VALID}, 64'd0);
        chk_eq("fl_wready", {63'd0, BUF_WREADY}, 64'd1);
        fill(1);
        drain(20);

        // Randomized 16-word bursts with random downstream stalls
        do_reset();
        sent = 0; left = 0; n = 0; pix0 = npix;
        while ((sent < 1200 || left > 0 || exp_q.size() != 0) && n < 20000) begin
            logic rv;
            logic pr;
            rv = (left > 0) && ($urandom_range(0, 3) != 0);
            w  = {$urandom, $urandom};
            pr = PIX_VALID && ($urandom_range(0, 3) != 0);
            if (rv) begin
                push_model(w);
                left--;
                sent++;
            end else if (left == 0 && sent < 1200 && BUF_WREADY) begin
                left = 16;
            end
            cyc(rv, w, pr, 1'b0);
            n++;
        end
        chk_eq("rand_left", 64'(exp_q.size()), 64'd0);
        chk_eq("rand_count", 64'(npix - pix0), 64'd2400);
        chk_eq("rand_ovf", {63'd0, ERR_OVF}, 64'd0);
        chk_eq("rand_udf", {63'd0, ERR_UDF}, 64'd0);
        drain(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
